// File: rtl/ain_pool.sv
// Frame pooling stage: groups FRAME_LEN accepted samples and emits max, index of max and saturating sum.
// Optional feature macro: AIN_POOL_SUM_EN builds the sum datapath; otherwise out_sum is tied to 0.
module ain_pool #(
    parameter int unsigned DATA_W    = 5,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned IDX_W     = $clog2(FRAME_LEN),
    parameter int unsigned SUM_W     = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_max,
    output logic [IDX_W-1:0]         out_idx,
    output logic signed [SUM_W-1:0]  out_sum
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_max_q, res_max_q, max_nx;
    logic [IDX_W-1:0]  acc_idx_q, res_idx_q, idx_nx;
    logic [DATA_W-1:0] d_c;
    logic              accept_c, last_c, first_c, gt_c;

    // Defensive clamp: negative samples count as 0
    assign d_c      = in_data[DATA_W-1] ? '0 : $unsigned(in_data);
    assign accept_c = in_valid && in_ready && !in_clear;
    assign last_c   = accept_c && (cnt_q == LAST_IDX);
    assign first_c  = (cnt_q == '0);
    assign gt_c     = d_c > acc_max_q;
    assign max_nx   = (first_c || gt_c) ? d_c : acc_max_q;
    assign idx_nx   = first_c ? '0 : (gt_c ? cnt_q : acc_idx_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ACCUM;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_c) state_d = HOLD;
            HOLD:    if (out_ready && !last_c) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = !out_valid || out_ready;
    end

    // Accumulators and result registers; clear drops only the partial frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            acc_max_q <= '0;
            acc_idx_q <= '0;
            res_max_q <= '0;
            res_idx_q <= '0;
        end else begin
            if (in_clear) begin
                cnt_q     <= '0;
                acc_max_q <= '0;
                acc_idx_q <= '0;
            end else if (accept_c) begin
                cnt_q     <= last_c ? '0 : cnt_q + IDX_W'(1);
                acc_max_q <= max_nx;
                acc_idx_q <= idx_nx;
            end
            if (last_c) begin
                res_max_q <= max_nx;
                res_idx_q <= idx_nx;
            end
        end
    end

    assign out_max = res_max_q;
    assign out_idx = res_idx_q;

`ifdef AIN_POOL_SUM_EN
    localparam int unsigned      EXT_W   = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;
    localparam logic [EXT_W-1:0] SUM_MAX = EXT_W'((1 << (SUM_W - 1)) - 1);

    logic [SUM_W-1:0] acc_sum_q, res_sum_q, sum_nx;
    logic [EXT_W-1:0] raw_c;

    assign raw_c  = (first_c ? '0 : EXT_W'(acc_sum_q)) + EXT_W'(d_c);
    assign sum_nx = (raw_c > SUM_MAX) ? SUM_W'(SUM_MAX) : SUM_W'(raw_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_sum_q <= '0;
            res_sum_q <= '0;
        end else begin
            if (in_clear)      acc_sum_q <= '0;
            else if (accept_c) acc_sum_q <= sum_nx;
            if (last_c)        res_sum_q <= sum_nx;
        end
    end

    assign out_sum = res_sum_q;
`else
    assign out_sum = '0;
`endif

endmodule
